// File: rtl/uart_pkg.sv
// Shared constants and register layouts for the UART receive FIFO.
package uart_pkg;

  localparam int unsigned STAT_EMPTY_BIT   = 31;
  localparam int unsigned STAT_OVERRUN_BIT = 30;
  localparam int unsigned STAT_FLUSH_BIT   = 29;
  localparam int unsigned THRESH_LSB       = 8;
  localparam int unsigned COUNT_LSB        = 0;
  localparam int unsigned BYTE_W           = 8;

  localparam logic [BYTE_W-1:0] THRESH_DEFAULT = 8'd1;

  // STATUS register read layout
  typedef struct packed {
    logic              empty;
    logic              overrun;
    logic [5:0]        rsvd_hi;
    logic [7:0]        rsvd_lo;
    logic [BYTE_W-1:0] threshold;
    logic [BYTE_W-1:0] count;
  } status_word_t;

  // DATA register read layout
  typedef struct packed {
    logic              empty;
    logic [22:0]       rsvd;
    logic [BYTE_W-1:0] data;
  } data_word_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO: storage, pointers and fill count with push/pop/flush.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              full_c,
  output logic              empty_c,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  count_next_c,
  output logic [BYTE_W-1:0] head_c
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign head_c  = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i & ~empty_c;
  assign do_push = push_i & (~full_c | do_pop) & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count_next_c = reset ? count_d : '0;
  assign count_o      = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with APB DATA/STATUS registers, overrun tracking and level irq.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              sel_data,
  input  logic              sel_status,
  input  logic              apb_enable,
  input  logic              apb_write,
  input  logic [31:0]       apb_wdata,
  output logic [31:0]       apb_rdata,
  output logic              irq
);

  logic              selbuf_data_q, selbuf_status_q;
  logic [BYTE_W-1:0] threshold_q, threshold_d;
  logic              overrun_q, overrun_d;
  logic              irq_q, irq_d;

  logic              rd_access, st_write, flush, drop, ovr_clear;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W:0]   fifo_count, fifo_count_next;
  logic [BYTE_W-1:0] fifo_head;
  status_word_t      status_w;
  data_word_t        data_w;
  logic              unused_wdata;

  assign unused_wdata = ^{apb_wdata[STAT_EMPTY_BIT], apb_wdata[28:16], apb_wdata[7:0]};

  // DATA wins when both selects are registered.
  assign rd_access = selbuf_data_q & apb_enable & ~apb_write;
  assign st_write  = selbuf_status_q & ~selbuf_data_q & apb_enable & apb_write;
  assign flush     = st_write & apb_wdata[STAT_FLUSH_BIT];
  assign ovr_clear = st_write & apb_wdata[STAT_OVERRUN_BIT];
  assign drop      = in_valid & fifo_full & ~rd_access & ~flush;

  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (in_valid),
    .data_i       (in_data),
    .pop_i        (rd_access),
    .flush_i      (flush),
    .full_c       (fifo_full),
    .empty_c      (fifo_empty),
    .count_o      (fifo_count),
    .count_next_c (fifo_count_next),
    .head_c       (fifo_head)
  );

  // Control next-state; irq looks at next-state values so it moves with the count.
  always_comb begin
    threshold_d = threshold_q;
    overrun_d   = overrun_q;
    irq_d       = irq_q;
    if (st_write) threshold_d = apb_wdata[THRESH_LSB +: BYTE_W];
    overrun_d = drop | (overrun_q & ~ovr_clear);
    irq_d     = overrun_d |
                ((threshold_d != '0) && (BYTE_W'(fifo_count_next) >= threshold_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      selbuf_data_q   <= 1'b0;
      selbuf_status_q <= 1'b0;
      threshold_q     <= THRESH_DEFAULT;
      overrun_q       <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      selbuf_data_q   <= sel_data;
      selbuf_status_q <= sel_status;
      threshold_q     <= threshold_d;
      overrun_q       <= overrun_d;
      irq_q           <= irq_d;
    end
  end

  // Read mux; DATA returns the pre-pop head during the access cycle.
  always_comb begin
    status_w           = '0;
    status_w.empty     = fifo_empty;
    status_w.overrun   = overrun_q;
    status_w.threshold = threshold_q;
    status_w.count     = BYTE_W'(fifo_count);
    data_w             = '0;
    data_w.empty       = fifo_empty;
    data_w.data        = fifo_head;
    apb_rdata          = '0;
    if (selbuf_data_q)        apb_rdata = data_w;
    else if (selbuf_status_q) apb_rdata = status_w;
  end

  assign irq = irq_q;

endmodule
